nibble_add16: RTL

NIBBLE_ADD16 -- requirements
Module: nibble_add16

---
 rtl/nibble_add16.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/nibble_add16.sv
// nibble_add16: multi-cycle adder/subtractor that processes one 4-bit slice
// per clock, LSB first, through a single carry-lookahead slice. Operands are
// captured on accept, the result is presented with valid/ready handshaking.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// RUN   | adding slice cnt_q, one per cycle
// DONE  | result and flags valid, waiting for out_ready
module nibble_add16 #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 sub,
  input  logic                 c_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out,
  output logic                 ovf,
  output logic                 zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          c_out_q, c_out_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;

  logic [3:0] sl_a, sl_b, sl_g, sl_p, sl_s;
  logic [4:0] sl_c;

  // Carry-lookahead slice over the nibble currently selected by cnt_q.
  always_comb begin
    sl_a = a_q[4*cnt_q +: 4];
    sl_b = b_q[4*cnt_q +: 4];
    sl_g = sl_a & sl_b;
    sl_p = sl_a ^ sl_b;
    sl_c[0] = carry_q;
    sl_c[1] = sl_g[0] | (sl_p[0] & carry_q);
    sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & carry_q);
    sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[2] & sl_p[1] & sl_p[0] & carry_q);
    sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & carry_q);
    sl_s = sl_p ^ sl_c[3:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, datapath next values and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so c_in is replaced by a forced 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[4*cnt_q +: 4] = sl_s;
        carry_d = sl_c[4];
        if (cnt_q == LAST) begin
          // Flags are frozen here from the completed sum so DONE holds them.
          c_out_d = sl_c[4];
          ovf_d   = (a_q[W-1] == b_q[W-1]) & (sum_d[W-1] != a_q[W-1]);
          zero_d  = (sum_d == '0);
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule
